// File: rtl/pixel_plotter.sv
// -----------------------------------------------------------------------------
// pixel_plotter
//
// Consumer end of the renderer coordinate stream. Pixels (x, y, colour) arrive
// over a valid/ready handshake, are buffered in a small in-order FIFO, clipped
// against the visible screen, converted to a linear framebuffer address
// (y*SCREEN_W + x) and issued as framebuffer writes over a request/ready
// handshake. The FIFO decouples renderer stalls from memory stalls.
//
// Optional feature macro: PLOT_TRANSPARENCY_EN
//   When defined, adds parameter TRANSPARENT_KEY; visible pixels whose colour
//   equals the key are dropped (counted in clip_count) instead of written.
//
// Ports:
//   clock         in   system clock, all state on rising edge
//   resetn        in   asynchronous active-low reset
//   in_valid      in   renderer presents a pixel
//   in_x          in   pixel x   [X_BITS]
//   in_y          in   pixel y   [Y_BITS]
//   in_colour     in   pixel colour [COLOUR_BITS]
//   in_ready      out  plotter can accept (FIFO not full)
//   mem_we        out  framebuffer write request
//   mem_addr      out  write address [ADDR_BITS]
//   mem_data      out  write colour [COLOUR_BITS]
//   mem_ready     in   framebuffer accepts write on this edge when mem_we=1
//   clear_counts  in   synchronous clear of both counters
//   plot_count    out  completed writes (16 bit, wrapping)
//   clip_count    out  dropped pixels (16 bit, wrapping)
//   idle          out  FIFO empty and no write pending
// -----------------------------------------------------------------------------
module pixel_plotter #(
  parameter int unsigned X_BITS      = 8,
  parameter int unsigned Y_BITS      = 7,
  parameter int unsigned COLOUR_BITS = 3,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned ADDR_BITS   = 15,
  parameter int unsigned DEPTH       = 4
`ifdef PLOT_TRANSPARENCY_EN
  ,
  parameter logic [COLOUR_BITS-1:0] TRANSPARENT_KEY = {COLOUR_BITS{1'b0}}
`endif
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  logic [X_BITS-1:0]      in_x,
  input  logic [Y_BITS-1:0]      in_y,
  input  logic [COLOUR_BITS-1:0] in_colour,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [COLOUR_BITS-1:0] mem_data,
  input  logic                   mem_ready,
  input  logic                   clear_counts,
  output logic [15:0]            plot_count,
  output logic [15:0]            clip_count,
  output logic                   idle
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PIX_W = X_BITS + Y_BITS + COLOUR_BITS;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  // FIFO storage and pointers
  logic [PIX_W-1:0]       fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;

  // Output register and counters
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [COLOUR_BITS-1:0] mem_data_q, mem_data_d;
  logic [15:0]            plot_count_q, plot_count_d;
  logic [15:0]            clip_count_q, clip_count_d;

  // Handshake / datapath helpers
  logic                   full_s, empty_s;
  logic                   push_s, pop_s, out_free_s, write_done_s;
  logic                   visible_s, keep_s;
  logic [X_BITS-1:0]      head_x_s;
  logic [Y_BITS-1:0]      head_y_s;
  logic [COLOUR_BITS-1:0] head_c_s;

  assign full_s       = (count_q == FULL_CNT);
  assign empty_s      = (count_q == {(PTR_W + 1){1'b0}});
  // in_ready depends only on occupancy: no bypass when full, even if a pop
  // happens on the same edge.
  assign push_s       = in_valid & ~full_s;
  assign write_done_s = mem_we_q & mem_ready;
  // The output register can take a new pixel if empty or draining this edge.
  assign out_free_s   = ~mem_we_q | mem_ready;
  assign pop_s        = out_free_s & ~empty_s;

  assign {head_x_s, head_y_s, head_c_s} = fifo_mem_q[rd_ptr_q];

  assign visible_s = (32'(head_x_s) < SCREEN_W) && (32'(head_y_s) < SCREEN_H);
`ifdef PLOT_TRANSPARENCY_EN
  assign keep_s    = visible_s && (head_c_s != TRANSPARENT_KEY);
`else
  assign keep_s    = visible_s;
`endif

  // Pointer, occupancy, output-register and counter next-state logic
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    plot_count_d = plot_count_q;
    clip_count_d = clip_count_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(PTR_W - 1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W - 1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    // A kept pixel loads the register; a dropped pop or a finished write
    // with nothing to replace it empties it; otherwise it holds (stall).
    if (pop_s && keep_s) begin
      mem_we_d   = 1'b1;
      mem_addr_d = ADDR_BITS'(32'(head_y_s) * SCREEN_W + 32'(head_x_s));
      mem_data_d = head_c_s;
    end else if (out_free_s) begin
      mem_we_d   = 1'b0;
    end else begin
      mem_we_d   = mem_we_q;
    end

    // Clear wins over a same-edge increment.
    if (clear_counts) begin
      plot_count_d = 16'd0;
      clip_count_d = 16'd0;
    end else begin
      if (write_done_s) begin
        plot_count_d = plot_count_q + 16'd1;
      end else begin
        plot_count_d = plot_count_q;
      end
      if (pop_s && !keep_s) begin
        clip_count_d = clip_count_q + 16'd1;
      end else begin
        clip_count_d = clip_count_q;
      end
    end
  end

  // FIFO data storage (payload only, no reset needed)
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {in_x, in_y, in_colour};
    end
  end

  // Control/state registers with asynchronous reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {(PTR_W + 1){1'b0}};
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_BITS{1'b0}};
      mem_data_q   <= {COLOUR_BITS{1'b0}};
      plot_count_q <= 16'd0;
      clip_count_q <= 16'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      plot_count_q <= plot_count_d;
      clip_count_q <= clip_count_d;
    end
  end

  assign in_ready   = ~full_s;
  assign idle       = empty_s & ~mem_we_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign plot_count = plot_count_q;
  assign clip_count = clip_count_q;

endmodule

// File: tb/tb_pixel_plotter.sv
// -----------------------------------------------------------------------------
// Testbench for pixel_plotter: directed scenarios plus random traffic, all
// checked every cycle against a queue-based behavioural model.
// -----------------------------------------------------------------------------
module tb_pixel_plotter;

  localparam int DEPTH = 4;
  localparam int SW    = 160;
  localparam int SH    = 120;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_x = 8'd0;
  logic [6:0]  in_y = 7'd0;
  logic [2:0]  in_colour = 3'd0;
  logic        in_ready;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_ready = 1'b1;
  logic        clear_counts = 1'b0;
  logic [15:0] plot_count;
  logic [15:0] clip_count;
  logic        idle;

  pixel_plotter dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_x(in_x),
    .in_y(in_y), .in_colour(in_colour), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .clear_counts(clear_counts), .plot_count(plot_count),
    .clip_count(clip_count), .idle(idle)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO as a queue, one pending write, two counters.
  typedef struct packed { logic [7:0] x; logic [6:0] y; logic [2:0] c; } pix_t;
  pix_t m_q[$];
  bit   m_we   = 1'b0;
  int   m_addr = 0;
  int   m_data = 0;
  int   m_plot = 0;
  int   m_clip = 0;
  int   obs_addr[$];
  int   obs_data[$];

  function automatic bit kept(input pix_t p);
    bit k;
    k = (int'(p.x) < SW) && (int'(p.y) < SH);
`ifdef PLOT_TRANSPARENCY_EN
    k = k && (p.c != 3'd0);
`endif
    return k;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_q.delete();
      m_we = 1'b0; m_addr = 0; m_data = 0; m_plot = 0; m_clip = 0;
    end else begin
      bit   acc;
      pix_t p;
      acc = in_valid && (m_q.size() < DEPTH);
      if (mem_we && mem_ready) begin
        obs_addr.push_back(int'(mem_addr));
        obs_data.push_back(int'(mem_data));
      end
      if (m_we && mem_ready) m_plot = (m_plot + 1) % 65536;
      if (!m_we || mem_ready) begin
        if (m_q.size() > 0) begin
          p = m_q.pop_front();
          if (kept(p)) begin
            m_we = 1'b1;
            m_addr = (int'(p.y) * SW + int'(p.x)) % 32768;
            m_data = int'(p.c);
          end else begin
            m_we = 1'b0;
            m_clip = (m_clip + 1) % 65536;
          end
        end else begin
          m_we = 1'b0;
        end
      end
      if (clear_counts) begin m_plot = 0; m_clip = 0; end
      if (acc) begin
        p.x = in_x; p.y = in_y; p.c = in_colour;
        m_q.push_back(p);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("in_ready", in_ready, (m_q.size() < DEPTH));
    chk("idle", idle, (m_q.size() == 0 && !m_we));
    chk("mem_we", mem_we, m_we);
    if (m_we) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data", mem_data, m_data);
    end
    chk("plot_count", plot_count, m_plot);
    chk("clip_count", clip_count, m_clip);
  end

  task automatic drive(input int x, input int y, input int c);
    in_valid = 1'b1;
    in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c);
    @(negedge clock);
  endtask

  task automatic clear_cnt();
    in_valid = 1'b0;
    clear_counts = 1'b1;
    @(negedge clock);
    clear_counts = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    in_valid = 1'b0;
    while (!idle && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("wait_idle", idle, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_plot", plot_count, 0);
    chk("rst_clip", clip_count, 0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Single pixel, one cycle after acceptance
    mem_ready = 1'b1;
    clear_cnt();
    drive(3, 2, 5);
    in_valid = 1'b0;
    @(negedge clock);
    chk("single_we", mem_we, 1);
    chk("single_addr", mem_addr, 323);
    chk("single_data", mem_data, 5);
    @(negedge clock);
    chk("single_we_drop", mem_we, 0);
    chk("single_plot", plot_count, 1);
    chk("single_idle", idle, 1);

    // Backpressure: 4 in FIFO + 1 in output register
    mem_ready = 1'b0;
    obs_addr.delete(); obs_data.delete();
    for (int i = 0; i < 5; i++) drive(i + 1, 1, i + 1);
    chk("bp_full", in_ready, 0);
    chk("bp_we", mem_we, 1);
    chk("bp_addr", mem_addr, 161);
    for (int i = 0; i < 3; i++) drive(100, 100, 7);
    chk("bp_addr_stable", mem_addr, 161);
    chk("bp_still_full", in_ready, 0);
    in_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clock);
    chk("bp_count", obs_addr.size(), 5);
    for (int i = 0; i < 5 && i < obs_addr.size(); i++)
      chk("bp_order", obs_addr[i], 161 + i);

    // Clipping
    clear_cnt();
    obs_addr.delete(); obs_data.delete();
    drive(160, 0, 1);
    drive(0, 120, 2);
    drive(159, 119, 3);
    wait_idle(20);
    chk("clip_writes", obs_addr.size(), 1);
    if (obs_addr.size() > 0) chk("clip_addr", obs_addr[0], 19199);
    chk("clip_plot", plot_count, 1);
    chk("clip_clip", clip_count, 2);

    // 4x4 square at (10,20)
    clear_cnt();
    obs_addr.delete(); obs_data.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        drive(10 + c, 20 + r, c + 1);
    wait_idle(30);
    chk("sq_writes", obs_addr.size(), 16);
    if (obs_addr.size() == 16) begin
      for (int i = 0; i < 16; i++)
        chk("sq_addr", obs_addr[i], (20 + i / 4) * SW + 10 + i % 4);
      chk("sq_first", obs_addr[0], 3210);
      chk("sq_last", obs_addr[15], 3693);
    end
    chk("sq_plot", plot_count, 16);

    // Reset mid-write with 3 buffered
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 0, 1);
    in_valid = 1'b0;
    chk("mid_we", mem_we, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clock);
    resetn = 1'b1;
    mem_ready = 1'b1;
    obs_addr.delete(); obs_data.delete();
    for (int i = 0; i < 5; i++) @(negedge clock);
    chk("mid_no_stale", obs_addr.size(), 0);
    chk("mid_plot", plot_count, 0);
    chk("mid_clip", clip_count, 0);
    chk("mid_idle", idle, 1);

    // Transparency key (0)
    clear_cnt();
    obs_addr.delete(); obs_data.delete();
    drive(5, 5, 0);
    drive(6, 5, 7);
    wait_idle(20);
`ifdef PLOT_TRANSPARENCY_EN
    chk("key_writes", obs_addr.size(), 1);
    if (obs_data.size() > 0) chk("key_data", obs_data[0], 7);
    chk("key_clip", clip_count, 1);
`else
    chk("key_writes", obs_addr.size(), 2);
    if (obs_data.size() > 1) chk("key_data", obs_data[1], 7);
    chk("key_clip", clip_count, 0);
`endif

    // Random traffic
    clear_cnt();
    for (int i = 0; i < 3000; i++) begin
      in_valid     = 1'($urandom_range(0, 1));
      in_x         = 8'($urandom_range(0, 179));
      in_y         = 7'($urandom_range(0, 127));
      in_colour    = 3'($urandom);
      mem_ready    = ($urandom_range(0, 3) != 0);
      clear_counts = ($urandom_range(0, 99) == 0);
      @(negedge clock);
    end
    clear_counts = 1'b0;
    mem_ready = 1'b1;
    wait_idle(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_plotter.md
Name: pixel_plotter

Overview:
Consumer end of the renderer coordinate stream. Accepts (x, y, colour) pixels from a renderer, such as the square renderer, through a valid/ready handshake. Buffers them in a small FIFO, clips off-screen pixels, and converts each accepted pixel to a linear framebuffer address. Issues framebuffer writes with a request/ready handshake, so renderer stalls and memory stalls are decoupled.

Parameters:
X_BITS, 8, width of x coordinate
Y_BITS, 7, width of y coordinate
COLOUR_BITS, 3, pixel colour width
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
ADDR_BITS, 15, framebuffer address width (must hold SCREEN_W*SCREEN_H-1)
DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous, active-low reset
in_valid  in  1  renderer presents a pixel
in_x  in  X_BITS  pixel x
in_y  in  Y_BITS  pixel y
in_colour  in  COLOUR_BITS  pixel colour
in_ready  out  1  plotter can accept; equals !fifo_full
mem_we  out  1  write request to framebuffer
mem_addr  out  ADDR_BITS  write address, y*SCREEN_W + x
mem_data  out  COLOUR_BITS  write colour
mem_ready  in  1  framebuffer accepts the write on this edge when mem_we=1
clear_counts  in  1  synchronous clear of both counters
plot_count  out  16  number of writes completed
clip_count  out  16  number of pixels dropped by clipping or keying
idle  out  1  FIFO empty and mem_we low

Behaviour:
- Reset (resetn low, asynchronous):
  - FIFO pointers and occupancy go to 0; mem_we=0; mem_addr=0; mem_data=0; both counters 0.
  - in_ready=1 and idle=1 combinationally.
- Push: on an edge with in_valid & in_ready, the pixel is written into the FIFO.
  - When the FIFO is full, in_ready=0 even if a pop occurs in the same cycle. There is no full-bypass.
- Output register: holds one pixel.
  - It is "free" when mem_we=0, or when mem_we=1 & mem_ready=1 on the current edge.
  - When free and the FIFO is non-empty, the head pixel is popped on that edge.
- Clipping: a popped pixel with x >= SCREEN_W or y >= SCREEN_H is discarded.
  - mem_we does not assert for it, and clip_count increments by 1.
  - A popped, clipped pixel still frees its FIFO slot; only one pixel is popped per cycle.
- Visible pixel: on the pop edge, mem_we<=1, mem_addr<=y*SCREEN_W+x (computed at full width, truncated to ADDR_BITS), mem_data<=colour.
- Latency: a pixel pushed into an empty FIFO with the output register free appears on mem_we after the following edge, i.e. one cycle after acceptance.
- Write handshake:
  - mem_we, mem_addr and mem_data stay stable while mem_we=1 and mem_ready=0.
  - On an edge with mem_we & mem_ready, plot_count increments. mem_we then either loads the next FIFO pixel (back-to-back, one write per cycle) or drops to 0.
- FIFO is in-order. The circular read and write pointers wrap at DEPTH. Occupancy ranges 0..DEPTH.
- Counters: 16-bit, wrap modulo 65536.
  - clear_counts has priority over an increment on the same edge; the result is 0.
- Simultaneous push and pop with a non-full FIFO: occupancy is unchanged and both operations take effect.
- Reset mid-operation: any pending write is abandoned (mem_we drops immediately) and buffered pixels are lost.

Optional Feature:
PLOT_TRANSPARENCY_EN
- Defined:
  - Adds parameter TRANSPARENT_KEY (default 0) of width COLOUR_BITS.
  - A visible popped pixel whose colour equals TRANSPARENT_KEY is discarded like a clipped pixel: no write, clip_count +1.
- Undefined: every visible pixel is written regardless of colour; no extra parameter or logic.

Test Plan:
- Single pixel: push x=3,y=2,colour=5 with mem_ready=1 held -> one cycle later mem_we=1, mem_addr=323, mem_data=5 for exactly one cycle; plot_count=1; idle returns to 1.
- Backpressure: mem_ready=0, push 5 pixels back-to-back -> 4 held in the FIFO plus 1 in the output register. in_ready falls to 0 once the FIFO is full, the 6th pixel is not accepted, and mem_addr stays stable. Release mem_ready -> 5 writes in order on consecutive cycles.
- Clipping: push (160,0), (0,120), (159,119) -> only one write at addr 19199; clip_count=2, plot_count=1.
- Stream from renderer: a 4x4 square at origin (10,20) -> 16 writes at addrs 3210..3213, 3370..3373, 3530..3533, 3690..3693, in order.
- Reset mid-write: assert resetn low while mem_we=1 with 3 pixels buffered -> mem_we=0 immediately; after release, idle=1, counters=0, no stale writes.
- Transparency (PLOT_TRANSPARENCY_EN, key=0): push colours 0, 7 -> one write with data 7; clip_count=1. With the macro undefined, the same stimulus gives 2 writes.
